// File: rtl/rr_arbiter_burst_pkg.sv
// Shared definitions for the round-robin burst arbiter: limits, config record
// and a one-hot to binary index helper.
package arb_pkg;

  localparam int ARB_MAX_N = 32;

  // Configuration record for reporting an arbiter instance's shape.
  typedef struct packed {
    logic [5:0] n;
    logic [7:0] max_burst;
  } arb_cfg_t;

  // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic logic [4:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_burst_pick.sv
// rr_pick: combinational rotating-priority search. Finds the first set bit of
// req at or above base, wrapping modulo N, using a double-width vector whose
// low half is masked below base so a plain lowest-bit search does the wrap.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] base,
  output logic             hit,
  output logic [IDX_W-1:0] winner_idx,
  output logic [N-1:0]     winner_onehot
);

  logic [N-1:0]         mask;
  logic [2*N-1:0]       dbl;
  logic [2*N-1:0]       dbl_oh;
  logic [ARB_MAX_N-1:0] oh_wide;

  // Keep only request bits at or above the search base in the low half.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(base));
    end
  end

  assign dbl = {req, req & mask};

  // Lowest set bit of the double-width vector; upper half covers the wrap.
  always_comb begin
    logic found;
    dbl_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < 2*N; i++) begin
      if (dbl[i] && !found) begin
        dbl_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign winner_onehot = dbl_oh[N-1:0] | dbl_oh[2*N-1:N];
  assign hit           = |req;
  assign oh_wide       = ARB_MAX_N'(winner_onehot);
  assign winner_idx    = IDX_W'(onehot_to_idx(oh_wide));

endmodule

// File: rtl/rr_arbiter_burst.sv
// rr_arbiter_burst: N-way round-robin arbiter with registered one-hot grant.
// An owner keeps the grant for up to MAX_BURST consecutive cycles while it
// keeps requesting; otherwise the search restarts one past the last winner.
// All outputs are registers; req never reaches an output combinationally.
module rr_arbiter_burst
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 4,
  localparam int IDX_W    = $clog2(N),
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             burst_last
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_oh;
  logic [IDX_W:0]   ptr_inc;
  logic [IDX_W-1:0] ptr_next;
  logic             hold;

  rr_pick #(.N(N)) u_pick (
    .req           (req),
    .base          (ptr),
    .hit           (pick_hit),
    .winner_idx    (pick_idx),
    .winner_onehot (pick_oh)
  );

  // Owner keeps the grant while requesting and the burst is not exhausted.
  assign hold    = grant_valid && (|(req & grant)) && (cnt < CNT_LAST);
  assign cnt_inc = cnt + CNT_W'(1);

  // Next search base is one past the winner, wrapped explicitly at N.
  assign ptr_inc  = {1'b0, pick_idx} + (IDX_W+1)'(1);
  assign ptr_next = (ptr_inc == (IDX_W+1)'(N)) ? '0 : ptr_inc[IDX_W-1:0];

  // Grant, burst counter and search base; everything frozen while en=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      burst_last  <= 1'b0;
      ptr         <= '0;
      cnt         <= '0;
    end else if (en) begin
      if (hold) begin
        cnt        <= cnt_inc;
        burst_last <= (cnt_inc == CNT_LAST);
      end else if (pick_hit) begin
        grant       <= pick_oh;
        grant_valid <= 1'b1;
        grant_idx   <= pick_idx;
        burst_last  <= (CNT_LAST == '0);
        cnt         <= '0;
        ptr         <= ptr_next;
      end else begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_idx   <= '0;
        burst_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter_burst.sv
// Bench for rr_arbiter_burst: four instances (N=4 MB=1, N=4 MB=4, N=4 MB=2,
// N=5 MB=3) share one request bus. A reference model predicts each edge's
// outputs into a queue; entries are popped and compared 1 ns after the edge.
module tb_rr_arbiter_burst;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] req;

  logic [3:0] g0, g1, g2;
  logic [4:0] g3;
  logic       gv0, gv1, gv2, gv3;
  logic [1:0] gi0, gi1, gi2;
  logic [2:0] gi3;
  logic       bl0, bl1, bl2, bl3;

  int n_chk = 0;
  int n_bad = 0;

  logic [11:0] exp_q[$];

  int cfg_n[4]  = '{4, 4, 4, 5};
  int cfg_mb[4] = '{1, 4, 2, 3};
  int m_ptr[4];
  int m_cnt[4];
  int m_owner[4];
  bit m_valid[4];

  // Clock
  always #5 clk = ~clk;

  rr_arbiter_burst #(.N(4), .MAX_BURST(1)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[3:0]),
    .grant(g0), .grant_valid(gv0), .grant_idx(gi0), .burst_last(bl0));
  rr_arbiter_burst #(.N(4), .MAX_BURST(4)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[3:0]),
    .grant(g1), .grant_valid(gv1), .grant_idx(gi1), .burst_last(bl1));
  rr_arbiter_burst #(.N(4), .MAX_BURST(2)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[3:0]),
    .grant(g2), .grant_valid(gv2), .grant_idx(gi2), .burst_last(bl2));
  rr_arbiter_burst #(.N(5), .MAX_BURST(3)) d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(g3), .grant_valid(gv3), .grant_idx(gi3), .burst_last(bl3));

  // Observed outputs packed as {valid, last, idx[4:0], grant[4:0]}.
  function automatic logic [11:0] obs(int k);
    case (k)
      0:       return {gv0, bl0, 5'(gi0), 5'(g0)};
      1:       return {gv1, bl1, 5'(gi1), 5'(g1)};
      2:       return {gv2, bl2, 5'(gi2), 5'(g2)};
      default: return {gv3, bl3, 5'(gi3), g3};
    endcase
  endfunction

  function automatic logic [11:0] model_exp(int k);
    logic [4:0] g, idx;
    logic       last;
    g    = m_valid[k] ? 5'(1 << m_owner[k]) : 5'd0;
    idx  = m_valid[k] ? 5'(m_owner[k]) : 5'd0;
    last = m_valid[k] && (m_cnt[k] == cfg_mb[k] - 1);
    return {m_valid[k], last, idx, g};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ptr[k] = 0; m_cnt[k] = 0; m_owner[k] = 0; m_valid[k] = 0;
    end
  endtask

  // One enabled edge of the reference arbiter for instance k.
  task automatic model_step(int k);
    bit found;
    int i;
    if (m_valid[k] && req[m_owner[k]] && (m_cnt[k] < cfg_mb[k] - 1)) begin
      m_cnt[k] = m_cnt[k] + 1;
    end else begin
      found = 0;
      for (int s = 0; s < cfg_n[k]; s++) begin
        i = (m_ptr[k] + s) % cfg_n[k];
        if (!found && req[i]) begin
          found = 1;
          m_owner[k] = i;
          m_cnt[k] = 0;
          m_valid[k] = 1;
          m_ptr[k] = (i + 1) % cfg_n[k];
        end
      end
      if (!found) begin
        m_valid[k] = 0;
        m_owner[k] = 0;
      end
    end
  endtask

  task automatic check(string tag, logic [11:0] o, logic [11:0] e);
    n_chk++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Driver: one clock edge, model update, push predictions, pop and compare.
  task automatic cycle(string phase);
    logic [11:0] e;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (en) model_step(k);
      exp_q.push_back(model_exp(k));
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $error("FAIL %s queue empty", phase);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_d%0d", phase, k), obs(k), e);
      end
    end
  endtask

  task automatic check_zero(string phase);
    for (int k = 0; k < 4; k++) check($sformatf("%s_d%0d", phase, k), obs(k), 12'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 5'd0;
    #2;
    do_reset();

    // Full request: pure rotation on MB=1, bursts elsewhere, wrap 4->0 on N=5.
    en = 1'b1; req = 5'b11111;
    for (int c = 0; c < 12; c++) begin
      cycle("all");
      if (c < 8) check($sformatf("rr1_c%0d", c), obs(0),
                       {1'b1, 1'b1, 5'(c % 4), 5'(1 << (c % 4))});
    end

    // Two competitors, 4-cycle bursts alternating 0 and 2.
    do_reset();
    en = 1'b1; req = 5'b00101;
    for (int c = 0; c < 12; c++) begin
      cycle("pair");
      check($sformatf("burst4_c%0d", c), obs(1),
            {1'b1, (c % 4) == 3, 5'(((c / 4) % 2) * 2), 5'(((c / 4) % 2 == 0) ? 1 : 4)});
    end

    // Owner releases early: no idle gap before requester 1 takes over.
    do_reset();
    en = 1'b1; req = 5'b00011;
    cycle("early"); cycle("early");
    check("early_own0", obs(1), {1'b1, 1'b0, 5'd0, 5'b00001});
    req = 5'b00010;
    cycle("early");
    check("early_take1", obs(1), {1'b1, 1'b0, 5'd1, 5'b00010});
    cycle("early"); cycle("early");

    // Lone requester: grant never drops across burst boundaries.
    do_reset();
    en = 1'b1; req = 5'b01000;
    for (int c = 0; c < 8; c++) begin
      cycle("lone");
      check($sformatf("lone2_c%0d", c), obs(2), {1'b1, (c % 2) == 1, 5'd3, 5'b01000});
    end

    // Freeze mid-burst with req wandering, then resume the remaining count.
    do_reset();
    en = 1'b1; req = 5'b00101;
    cycle("frz"); cycle("frz");
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req = 5'($urandom_range(0, 31));
      cycle("frz_off");
      check($sformatf("frz_hold_c%0d", c), obs(1), {1'b1, 1'b0, 5'd0, 5'b00001});
    end
    en = 1'b1; req = 5'b00101;
    cycle("frz_on"); cycle("frz_on");
    check("frz_resume_last", obs(1), {1'b1, 1'b1, 5'd0, 5'b00001});
    for (int c = 0; c < 4; c++) cycle("frz_on");

    // Asynchronous reset between edges mid-burst, then restart from ptr=0.
    do_reset();
    en = 1'b1; req = 5'b11111;
    cycle("arst"); cycle("arst"); cycle("arst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("arst_now");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("arst_rel");
    check("arst_first", obs(3), {1'b1, 1'b0, 5'd0, 5'b00001});
    for (int c = 0; c < 14; c++) cycle("arst_rel");

    // Random requests and enables.
    for (int c = 0; c < 60; c++) begin
      req = 5'($urandom_range(0, 31));
      en  = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    if (exp_q.size() != 0) begin
      n_chk++; n_bad++;
      $error("FAIL leftover queue size=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_burst.md
Name: rr_arbiter_burst

Overview:
- Parametrised N-way round-robin arbiter with registered one-hot grant and per-owner burst hold.
- Grants one requester at a time. Rotates fairly starting from the requester after the last owner.
- An owner may keep the grant for up to MAX_BURST consecutive cycles while it keeps requesting.
- Sits in front of shared resources (bus slave, memory port); replaces the fixed 4-way arbiter.

Parameters:
- N, 4, number of requesters (2..32).
- MAX_BURST, 4, maximum consecutive grant cycles per ownership (1 = pure per-cycle round-robin).
- IDX_W, $clog2(N), width of grant index (derived, not overridden).
- CNT_W, $clog2(MAX_BURST+1), burst counter width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbitration enable; when 0, all state is frozen and grant is held.
- req  in  N  request vector; bit i = requester i.
- grant  out  N  registered one-hot grant, or all-zero.
- grant_valid  out  1  registered; equals |grant.
- grant_idx  out  IDX_W  registered binary index of the granted requester; 0 when grant_valid=0.
- burst_last  out  1  registered; 1 when the current grant cycle is the owner's final permitted cycle (cnt == MAX_BURST-1).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - grant=0, grant_valid=0, grant_idx=0, burst_last=0.
  - ptr=0 (search base), cnt=0.
  - Takes effect immediately; a grant in progress is dropped with no completion cycle.
- Latency: req sampled at edge k is reflected in grant after edge k (one cycle). Combinational paths from req to outputs are not permitted.
- State:
  - ptr (IDX_W): index where the next fair search begins.
  - cnt (CNT_W): cycles the current owner has held the grant, minus 1.
  - owner: the currently granted index.
- Next-grant decision, each edge with en=1:
  - Hold: grant_valid=1, req[owner]=1 and cnt < MAX_BURST-1 → keep owner; cnt += 1.
  - Rotate: otherwise, search req from ptr upward, wrapping modulo N; the first set bit wins.
  - The winner becomes owner with cnt=0; ptr = (winner+1) mod N.
  - Rotation when the burst is exhausted: the search also includes the old owner. Because ptr = owner+1, the old owner is reached last, so it is re-granted (cnt=0) only if no other requester is asserting.
  - Owner drops req: rotation happens the same edge. There is no idle gap if another requester is asserting.
  - req all-zero: grant=0, grant_valid=0, grant_idx=0; ptr and cnt unchanged.
- en=0: all registers hold, including outputs. req is ignored.
- Wrap: ptr = N-1 after a grant to N-2; the search order is then N-1, 0, 1, …
- Non-power-of-2 N: search indices ≥ N never exist. ptr increments with explicit wrap, not a bitwidth overflow.
- Arithmetic: cnt saturates at MAX_BURST-1 and never wraps. ptr+1 compare is done at IDX_W+1 bits.
- MAX_BURST=1: the hold branch is never taken, so every requester gets at most 1 consecutive cycle when others compete. burst_last=1 whenever grant_valid=1.
- Invariants:
  - grant is one-hot-or-zero at all times.
  - grant_idx is consistent with grant.
  - A requester holding req continuously is granted within (N-1)*MAX_BURST+1 cycles (starvation bound).

Decomposition:
- Package arb_pkg holds:
  - the arb_cfg_t struct (n, max_burst) for configuration reporting;
  - the function onehot_to_idx;
  - the localparam ARB_MAX_N=32.
- One sub-module, rr_pick: purely combinational rotating-priority search.
  - Parameter N; inputs req, base; outputs hit, winner_idx, winner_onehot.
  - Implemented with the double-width masked-priority technique.
- Top module holds all registers (ptr, cnt, grant) and the hold/rotate control.

Test Plan:
- Reset then req=4'b1111 held, MAX_BURST=1, N=4 → grant 0001, 0010, 0100, 1000, 0001…; grant_idx 0,1,2,3,0.
- N=4, MAX_BURST=4, req=4'b0101 held → grant 0001 for 4 cycles (burst_last on the 4th), then 0100 for 4 cycles, then 0001 again.
- Owner releases early: MAX_BURST=4, req=0011; drop req[0] after 2 grant cycles → next edge grant=0010 with no zero cycle.
- Lone requester: req=4'b1000 held, MAX_BURST=2 → grant stays 1000 continuously; cnt resets each burst_last; grant_valid never drops.
- en=0 for 3 cycles mid-burst with req changing → grant, grant_idx and burst_last frozen. On en=1, the burst resumes with the remaining count.
- Async reset mid-burst (rst_n low between edges) → grant=0 immediately. After release with req=1111, the first grant is 0001 (ptr=0). Repeat the same sequence with N=5 to check wrap 4→0.
